// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// One frame shifter plus a one-entry holding register.
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bits;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] word;
  logic                 hold_full;
  logic                 par_bit;
  logic                 bit_end;
  logic                 frame_end;
  logic                 xfer;
  logic                 direct;
  logic                 load;
  logic                 serial_nx;

  function automatic logic parity_of(
    input logic [DATA_BITS-1:0] w
  );
    if (PARITY == 2) begin
      return ~(^w);
    end
    return ^w;
  endfunction

  assign xfer      = data_valid & data_ready;
  assign bit_end   = (state != IDLE) &&
                     (baud == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end &&
                     (bits == STOP_LAST);
  // A word goes straight to the shifter when the
  // line is free now; otherwise it waits in hold.
  assign direct    = xfer &&
                     ((state == IDLE) || frame_end);
  assign load      = direct ||
                     (frame_end && hold_full);
  assign word      = hold_full ? hold : data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode on bit boundaries and loads.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load) state_nx = START;
      end
      START: begin
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        if (bit_end && (bits == DATA_LAST)) begin
          state_nx = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (frame_end) begin
          state_nx = load ? START : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode and the next line level.
  always_comb begin
    busy       = (state != IDLE);
    data_ready = ~hold_full;
    serial_nx  = serial_out;
    if (load) begin
      serial_nx = 1'b0;
    end else if (bit_end) begin
      case (state_nx)
        DATA:    serial_nx = shift[0];
        PAR:     serial_nx = par_bit;
        default: serial_nx = 1'b1;
      endcase
    end
  end

  // Line register and frame-end pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      serial_out <= serial_nx;
      tx_done    <= frame_end;
    end
  end

  // Baud counter: clears on each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud <= '0;
    end else if (load || bit_end ||
                 (state == IDLE)) begin
      baud <= '0;
    end else begin
      baud <= baud + 1'b1;
    end
  end

  // Bit counter within the DATA and STOP phases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits <= '0;
    end else if (load) begin
      bits <= '0;
    end else if (bit_end) begin
      if (state_nx != state) begin
        bits <= '0;
      end else begin
        bits <= bits + 1'b1;
      end
    end
  end

  // Frame shifter and its parity, fixed at load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (load) begin
      shift   <= word;
      par_bit <= parity_of(word);
    end else if (bit_end && (state_nx == DATA)) begin
      shift   <= shift >> 1;
    end
  end

  // Holding register for a word arriving mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (xfer && !direct) begin
      hold      <= data;
      hold_full <= 1'b1;
    end else if (frame_end && hold_full) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: bench for uart_tx_cfg.
// Line-level model built from frame rules.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] dd  [4];
  logic       dv  [4];
  logic       rdy [4];
  logic       so  [4];
  logic       bsy [4];
  logic       dn  [4];

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_BITS(8), .CLKS_PER_BIT(4),
    .PARITY(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst), .data(dd[0][7:0]),
    .data_valid(dv[0]), .data_ready(rdy[0]),
    .serial_out(so[0]), .busy(bsy[0]), .tx_done(dn[0])
  );

  uart_tx_cfg #(
    .DATA_BITS(8), .CLKS_PER_BIT(4),
    .PARITY(1), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst), .data(dd[1][7:0]),
    .data_valid(dv[1]), .data_ready(rdy[1]),
    .serial_out(so[1]), .busy(bsy[1]), .tx_done(dn[1])
  );

  uart_tx_cfg #(
    .DATA_BITS(8), .CLKS_PER_BIT(4),
    .PARITY(2), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst), .data(dd[2][7:0]),
    .data_valid(dv[2]), .data_ready(rdy[2]),
    .serial_out(so[2]), .busy(bsy[2]), .tx_done(dn[2])
  );

  uart_tx_cfg #(
    .DATA_BITS(5), .CLKS_PER_BIT(4),
    .PARITY(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst), .data(dd[3][4:0]),
    .data_valid(dv[3]), .data_ready(rdy[3]),
    .serial_out(so[3]), .busy(bsy[3]), .tx_done(dn[3])
  );

  int sel;
  int c_db;
  int c_cpb;
  int c_par;
  int c_stop;
  int checks = 0;
  int errors = 0;

  // Expected line, one entry per cycle: {last, level}.
  logic [1:0] q[$];
  int         frames;
  bit         exp_done;

  task automatic chk(input string tag,
                     input logic [8:0] obs,
                     input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int s);
    sel    = s;
    c_db   = (s == 3) ? 5 : 8;
    c_cpb  = 4;
    c_par  = (s == 1) ? 1 : (s == 2) ? 2 : 0;
    c_stop = (s == 3) ? 2 : 1;
  endtask

  task automatic add_bit(input logic lvl,
                         input bit last);
    for (int k = 0; k < c_cpb; k++) begin
      q.push_back({last && (k == c_cpb - 1), lvl});
    end
  endtask

  task automatic push_frame(input logic [8:0] w);
    logic p;
    p = 1'b0;
    add_bit(1'b0, 0);
    for (int i = 0; i < c_db; i++) begin
      add_bit(w[i], 0);
      p = p ^ w[i];
    end
    if (c_par == 2) p = ~p;
    if (c_par != 0) add_bit(p, 0);
    for (int s = 0; s < c_stop; s++) begin
      add_bit(1'b1, s == c_stop - 1);
    end
    frames++;
  endtask

  task automatic model_edge(input bit x,
                            input logic [8:0] w);
    logic [1:0] s;
    exp_done = 0;
    if (q.size() > 0) begin
      s = q.pop_front();
      if (s[1]) begin
        exp_done = 1;
        frames--;
      end
    end
    if (x) push_frame(w);
  endtask

  task automatic check_all(input string tag);
    logic lvl;
    lvl = (q.size() > 0) ? q[0][0] : 1'b1;
    chk({tag, ".serial"}, 9'(so[sel]), 9'(lvl));
    chk({tag, ".busy"}, 9'(bsy[sel]),
        9'(q.size() > 0));
    chk({tag, ".ready"}, 9'(rdy[sel]),
        9'(frames <= 1));
    chk({tag, ".done"}, 9'(dn[sel]), 9'(exp_done));
  endtask

  task automatic chk_reset(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, ".serial"}, 9'(so[k]), 9'd1);
      chk({tag, ".busy"}, 9'(bsy[k]), 9'd0);
      chk({tag, ".done"}, 9'(dn[k]), 9'd0);
      chk({tag, ".ready"}, 9'(rdy[k]), 9'd1);
    end
  endtask

  task automatic cycle(input string tag,
                       input bit v,
                       input logic [8:0] d,
                       output bit x);
    logic [8:0] m;
    m = 9'((1 << c_db) - 1);
    dv[sel] = v;
    dd[sel] = d;
    x = v && (frames <= 1);
    @(posedge clk);
    model_edge(x, d & m);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    bit x;
    repeat (n) cycle(tag, 1'b0, 9'd0, x);
  endtask

  task automatic drain(input string tag);
    idle(tag, q.size() + 2);
  endtask

  task automatic send(input string tag,
                      input logic [8:0] w);
    bit x;
    cycle(tag, 1'b1, w, x);
    chk({tag, ".accept"}, 9'(x), 9'd1);
    drain(tag);
  endtask

  initial begin
    bit x;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      dd[k] = '0;
    end
    frames   = 0;
    exp_done = 0;
    set_cfg(0);
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    idle("idle", 3);

    send("a5", 9'h0A5);

    cycle("b2b", 1'b1, 9'h055, x);
    idle("b2b", 11);
    cycle("b2b", 1'b1, 9'h0AA, x);
    chk("b2b.accept", 9'(x), 9'd1);
    drain("b2b");

    cycle("abort", 1'b1, 9'h03C, x);
    cycle("abort", 1'b1, 9'h099, x);
    idle("abort", 15);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    q.delete();
    frames   = 0;
    exp_done = 0;
    dv[sel]  = 1'b0;
    @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    idle("post", 2);
    send("c3", 9'h0C3);

    set_cfg(1);
    send("even07", 9'h007);
    set_cfg(2);
    send("odd03", 9'h003);
    send("odd07", 9'h007);
    set_cfg(3);
    send("d5s2", 9'h01F);

    for (int s = 0; s < 4; s++) begin
      set_cfg(s);
      repeat (250) begin
        cycle("rnd", $urandom_range(0, 3) != 0,
              9'($urandom), x);
      end
      repeat (150) begin
        cycle("cont", 1'b1, 9'($urandom), x);
      end
      drain("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
